// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------+
// | seg_pkg: seven-segment code type and digit/dash/blank constants.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  // Byte layout {dp,g,f,e,d,c,b,a}, active-high (lit segment = 1).
  typedef logic [7:0] seg_code_t;

  localparam seg_code_t SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam seg_code_t SEG_DASH  = 8'h40;
  localparam seg_code_t SEG_BLANK = 8'h00;

endpackage : seg_pkg

`default_nettype wire

// File: rtl/digit_to_segment.sv
// +----------------------------------------------------------------------+
// | digit_to_segment: 4-bit digit to active-high 7-seg code (comb.).     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module digit_to_segment
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output seg_code_t  code
);

  // Codes 10..15 fall through to dash, which the top uses for out-of-range.
  always_comb begin
    code = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) begin
        code = SEG_DIGIT[i];
      end
    end
  end

endmodule : digit_to_segment

`default_nettype wire

// File: rtl/time_to_segment.sv
// +----------------------------------------------------------------------+
// | time_to_segment: binary 0..MAX_VALUE to two registered 7-seg codes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module time_to_segment
  import seg_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned MAX_VALUE  = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_data,
  output logic [15:0] seg_data
);

  if (MAX_VALUE > 99) begin : g_max_value_check
    $error("time_to_segment: MAX_VALUE must not exceed 99");
  end

  localparam logic [15:0] c_polarity_mask = ACTIVE_LOW ? 16'hFFFF : 16'h0000;
  localparam logic [15:0] c_reset_code    = {SEG_BLANK, SEG_BLANK} ^ c_polarity_mask;

  logic       w_in_range;
  logic [6:0] w_value;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_tens_sel;
  logic [3:0] w_ones_sel;
  seg_code_t  w_tens_code;
  seg_code_t  w_ones_code;
  logic [15:0] w_seg_next;
  logic [15:0] r_seg_data;

  // In range implies the upper 25 bits are zero, so the low 7 bits suffice.
  assign w_in_range = (time_data <= 32'(MAX_VALUE));
  assign w_value    = time_data[6:0];
  assign w_tens     = 4'(w_value / 7'd10);
  assign w_ones     = 4'(w_value % 7'd10);

  // Digit value 15 is not a decimal digit, so the encoder emits a dash.
  assign w_tens_sel = w_in_range ? w_tens : 4'hF;
  assign w_ones_sel = w_in_range ? w_ones : 4'hF;

  digit_to_segment u_tens (
    .digit (w_tens_sel),
    .code  (w_tens_code)
  );

  digit_to_segment u_ones (
    .digit (w_ones_sel),
    .code  (w_ones_code)
  );

  assign w_seg_next = {w_tens_code, w_ones_code} ^ c_polarity_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_data <= c_reset_code;
    end else begin
      r_seg_data <= w_seg_next;
    end
  end

  assign seg_data = r_seg_data;

endmodule : time_to_segment

`default_nettype wire

// File: tb/tb_time_to_segment.sv
// +----------------------------------------------------------------------+
// | tb_time_to_segment: checks both polarities against a decimal model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_time_to_segment;

  logic        clk;
  logic        rst;
  logic [31:0] time_data;
  logic [15:0] seg_hi;
  logic [15:0] seg_lo;

  int total = 0;
  int bad   = 0;

  time_to_segment #(.ACTIVE_LOW(1'b0), .MAX_VALUE(99)) dut (
    .clk       (clk),
    .rst       (rst),
    .time_data (time_data),
    .seg_data  (seg_hi)
  );

  time_to_segment #(.ACTIVE_LOW(1'b1), .MAX_VALUE(99)) dut_n (
    .clk       (clk),
    .rst       (rst),
    .time_data (time_data),
    .seg_data  (seg_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ref_digit(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h40;
    endcase
  endfunction

  // Decimal display of a number: two digits if it fits, else dash dash.
  function automatic logic [15:0] ref_seg(input logic [31:0] v, input bit al);
    logic [15:0] r;
    if (v > 32'd99) r = 16'h4040;
    else            r = {ref_digit(int'(v / 10)), ref_digit(int'(v % 10))};
    return al ? ~r : r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h want 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output reflects the value driven at the previous falling edge.
  task automatic apply_and_check(input string name, input logic [31:0] v,
                                 input logic [15:0] exp_hi);
    @(negedge clk);
    time_data = v;
    @(negedge clk);
    check({name, "_hi"}, seg_hi, exp_hi);
    check({name, "_lo"}, seg_lo, ~exp_hi);
  endtask

  initial begin
    rst       = 1'b1;
    time_data = 32'd0;

    // Reset holds blank even with a new input present.
    @(negedge clk);
    time_data = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_blank_hi", seg_hi, 16'h0000);
      check("rst_blank_lo", seg_lo, 16'hFFFF);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_hi", seg_hi, 16'h3F07);
    check("rst_release_lo", seg_lo, 16'hC0F8);

    // Counting 0..19 and wrap; each value visible one cycle later.
    for (int i = 0; i <= 20; i++) begin
      logic [31:0] v;
      v = 32'(i % 20);
      @(negedge clk);
      time_data = v;
      @(posedge clk);
      #1;
      check("count_hi", seg_hi, ref_seg(v, 1'b0));
      check("count_lo", seg_lo, ref_seg(v, 1'b1));
    end

    // Fixed vectors from the decimal digit table.
    vecs.push_back('{32'd0,          16'h3F3F});
    vecs.push_back('{32'd5,          16'h3F6D});
    vecs.push_back('{32'd9,          16'h3F6F});
    vecs.push_back('{32'd10,         16'h063F});
    vecs.push_back('{32'd19,         16'h066F});
    vecs.push_back('{32'd20,         16'h5B3F});
    vecs.push_back('{32'd42,         16'h665B});
    vecs.push_back('{32'd58,         16'h6D7F});
    vecs.push_back('{32'd77,         16'h0707});
    vecs.push_back('{32'd99,         16'h6F6F});
    vecs.push_back('{32'd100,        16'h4040});
    vecs.push_back('{32'd127,        16'h4040});
    vecs.push_back('{32'h0000_0105,  16'h4040});
    vecs.push_back('{32'h8000_0000,  16'h4040});
    vecs.push_back('{32'hFFFF_FFFF,  16'h4040});
    foreach (vecs[i]) begin
      apply_and_check($sformatf("vec_%0d", vecs[i].val), vecs[i].val, vecs[i].exp);
    end

    // Back-to-back inputs: each appears exactly one cycle after it is driven.
    @(negedge clk);
    time_data = 32'd42;
    @(negedge clk);
    check("b2b_42", seg_hi, 16'h665B);
    time_data = 32'd58;
    @(negedge clk);
    check("b2b_58", seg_hi, 16'h6D7F);

    // Active-low instance on a single digit value.
    apply_and_check("al_5", 32'd5, 16'h3F6D);
    check("al_5_const", seg_lo, 16'hC092);

    // Asynchronous reset between edges clears before the next edge.
    apply_and_check("pre_async", 32'd19, 16'h066F);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hi", seg_hi, 16'h0000);
    check("async_rst_lo", seg_lo, 16'hFFFF);
    @(negedge clk);
    check("async_hold_hi", seg_hi, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("async_release_hi", seg_hi, 16'h066F);

    // Random values, biased toward the in-range/out-of-range boundary.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = 32'($urandom_range(95, 105));
        default: v = 32'($urandom_range(0, 99));
      endcase
      @(negedge clk);
      time_data = v;
      @(negedge clk);
      check("rand_hi", seg_hi, ref_seg(v, 1'b0));
      check("rand_lo", seg_lo, ref_seg(v, 1'b1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_time_to_segment

`default_nettype wire

// File: doc/time_to_segment.md
Name: time_to_segment

Overview:
- Converts a binary time value (one clock field, 0..99) into two 8-bit seven-segment codes: tens digit and ones digit.
- Sits between the clock counter logic and the display scanner.
- Output is registered: one cycle of latency from input to display code.

Parameters:
- ACTIVE_LOW, default 0: 0 means a lit segment is 1; 1 inverts all 16 output bits, for common-anode displays.
- MAX_VALUE, default 99: largest value that is displayed numerically; must be ≤ 99.

Ports:
- clk  input  1  system clock, rising edge active.
- rst  input  1  asynchronous, active-high reset.
- time_data  input  32  unsigned binary value to display.
- seg_data  output  16  [15:8] = tens digit code, [7:0] = ones digit code.

Behaviour:
- Each byte is laid out {dp,g,f,e,d,c,b,a}; bit 0 is segment a. Decimal point (bit 7) is always unlit.
- Digit codes, in active-high form:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - dash=0x40, blank=0x00
- Value path:
  - If time_data ≤ MAX_VALUE: tens = time_data/10, ones = time_data%10, computed combinationally on the low 7 bits. All upper bits are zero in this case.
  - If time_data > MAX_VALUE, including any upper-bit set: both digits show dash (0x4040).
- No leading-zero blanking: 5 displays as "05" (0x3F6D).
- Polarity: if ACTIVE_LOW=1, the full 16-bit result is bitwise inverted before the register.
- Timing: seg_data registers the encoded result on every rising clk edge. An input change becomes visible one cycle later, with no handshake and no enable.
- Reset:
  - While rst=1, seg_data is immediately forced to the blank code: 0x0000 (ACTIVE_LOW=0) or 0xFFFF (ACTIVE_LOW=1).
  - Reset mid-operation overrides any pending value.
  - The first edge after rst deasserts loads the current input.
- Boundaries:
  - 0 → "00"; 99 → "99".
  - 100 and 0xFFFFFFFF → dash dash.
  - 9→10 and 19→20 transitions update the tens digit in the same cycle as the ones digit; no intermediate mixed state.
- X/unknown input bits are not handled specially.

Decomposition:
- Shared package seg_pkg holds:
  - the SEG_DIGIT constant array (0..9 codes);
  - SEG_DASH and SEG_BLANK constants;
  - the 8-bit seg_code_t typedef.
- One sub-module, digit_to_segment: a 4-bit digit in, 8-bit active-high code out, combinational.
  - It returns SEG_DASH for inputs 10..15.
  - It is instantiated twice, for tens and ones.
- The top level does range checking, divide/modulo, polarity inversion and the output register.

Test Plan:
- Assert rst, then apply time_data=7 while rst is held → seg_data=0x0000 throughout. Release rst → 0x3F07 one cycle later.
- Count time_data 0..19 with wrap, one step per 10 time units → codes track one cycle later: 0→0x3F3F, 9→0x3F6F, 10→0x063F, 19→0x066F, then 0 again → 0x3F3F.
- time_data=99 → 0x6F6F; time_data=100 → 0x4040; time_data=0xFFFFFFFF → 0x4040.
- Change input on consecutive cycles 42, 58 → outputs 0x665B then 0x6D7F on the following cycles, confirming one-cycle latency.
- ACTIVE_LOW=1 instance, time_data=5 → 0xC092; during reset → 0xFFFF.
- Assert rst asynchronously between clock edges while displaying 0x066F → output goes to 0x0000 before the next edge.
